// File: rtl/rtc_bus_master.sv
// rtc_bus_master: burst-capable multiplexed AD-bus master for an external RTC chip, driven from PicoBlaze ports.
// Define RTCBUS_AUTOINC_EN to step the register address by one after every transfer of a burst.
module rtc_bus_master #(
  parameter int DW      = 8,
  parameter int DEPTH   = 4,
  parameter int T_ADDR  = 6,
  parameter int T_TURN  = 9,
  parameter int T_DATA  = 6,
  parameter int T_RECOV = 11
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          writef,
  input  logic          readf,
  input  logic [7:0]    id_port,
  input  logic [DW-1:0] dpico,
  output logic [DW-1:0] port_out,
  input  logic [DW-1:0] ADin,
  output logic [DW-1:0] ADout,
  output logic          ad,
  output logic          cs,
  output logic          wr,
  output logic          rd,
  output logic          Pup,
  output logic [7:0]    ready,
  output logic          busy,
  output logic [3:0]    dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef RTCBUS_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_A_AL, S_A_CS, S_A_WR, S_A_E1, S_A_E2, S_A_E3,
    S_TURN, S_D_CS, S_D_STB, S_D_END, S_RECOV
  } state_t;

  state_t        state, state_nxt;
  logic [15:0]   phase_cnt, phase_len;
  logic          phase_last;
  logic [DW-1:0] addr_reg, cur_addr;
  logic          addr_dirty;
  logic [AW:0]   count_reg, remaining;
  logic          is_read, err;

  logic [DW-1:0] wf_mem [DEPTH];
  logic [AW-1:0] wf_wp, wf_rp;
  logic [AW:0]   wf_cnt;
  logic [DW-1:0] rf_mem [DEPTH];
  logic [AW-1:0] rf_wp, rf_rp;
  logic [AW:0]   rf_cnt;

  // PicoBlaze strobes are one-cycle qualifiers: an access with writef/readf high is
  // taken on that clock edge unconditionally; there is no back-pressure, so a push
  // into a full FIFO or a command while busy is simply dropped.
  logic port_addr_wr, port_cmd_wr, port_data_wr, port_cnt_wr, port_rf_pop;
  logic cmd_rd, cmd_wr, wr_ok, start, reject;
  logic xfer_done, burst_done;
  logic wf_push, wf_pop, wf_full, rf_push, rf_pop, rf_clr;
  logic [7:0] status;

  assign port_addr_wr = writef && (id_port == 8'h00);
  assign port_cmd_wr  = writef && (id_port == 8'h01);
  assign port_data_wr = writef && (id_port == 8'h02);
  assign port_cnt_wr  = writef && (id_port == 8'h03);
  assign port_rf_pop  = readf  && (id_port == 8'h04);

  assign busy       = (state != S_IDLE);
  assign dbg_state  = state;
  assign cmd_rd     = port_cmd_wr && !busy && (dpico == DW'(1));
  assign cmd_wr     = port_cmd_wr && !busy && (dpico == DW'(2));
  assign wr_ok      = (wf_cnt >= count_reg);
  assign start      = cmd_rd || (cmd_wr && wr_ok);
  assign reject     = cmd_wr && !wr_ok;
  assign xfer_done  = (state == S_RECOV) && phase_last;
  assign burst_done = xfer_done && (remaining == (AW+1)'(1));

  assign wf_full = (wf_cnt == (AW+1)'(DEPTH));
  assign wf_push = port_data_wr && !wf_full;
  assign wf_pop  = (state == S_D_END) && !is_read && (wf_cnt != '0);
  assign rf_clr  = start && cmd_rd;
  assign rf_push = (state == S_D_STB) && phase_last && is_read && (rf_cnt != (AW+1)'(DEPTH));
  assign rf_pop  = port_rf_pop && (rf_cnt != '0);

  // Address-latch and data chip-select setup take two cycles each, so that one
  // transfer is 9 fixed cycles plus the four programmable phases.
  always_comb begin
    phase_len = 16'd1;
    case (state)
      S_A_AL, S_D_CS: phase_len = 16'd2;
      S_A_WR:         phase_len = 16'(T_ADDR);
      S_TURN:         phase_len = 16'(T_TURN);
      S_D_STB:        phase_len = 16'(T_DATA);
      S_RECOV:        phase_len = 16'(T_RECOV);
      default:        phase_len = 16'd1;
    endcase
  end
  assign phase_last = (phase_cnt == phase_len - 16'd1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      phase_cnt <= '0;
    end else begin
      state     <= state_nxt;
      phase_cnt <= (state == S_IDLE || phase_last) ? 16'd0 : phase_cnt + 16'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    ad    = 1'b1;
    cs    = 1'b1;
    wr    = 1'b1;
    rd    = 1'b1;
    Pup   = 1'b0;
    ADout = '1;
    case (state)
      S_IDLE:  if (start) state_nxt = S_A_AL;
      S_A_AL:  begin ad = 1'b0; if (phase_last) state_nxt = S_A_CS; end
      S_A_CS:  begin ad = 1'b0; cs = 1'b0; if (phase_last) state_nxt = S_A_WR; end
      S_A_WR: begin
        ad = 1'b0; cs = 1'b0; wr = 1'b0; ADout = cur_addr;
        if (phase_last) state_nxt = S_A_E1;
      end
      S_A_E1: begin
        ad = 1'b0; cs = 1'b0; ADout = cur_addr;
        if (phase_last) state_nxt = S_A_E2;
      end
      S_A_E2:  begin ad = 1'b0; if (phase_last) state_nxt = S_A_E3; end
      S_A_E3:  if (phase_last) state_nxt = S_TURN;
      S_TURN:  begin Pup = is_read; if (phase_last) state_nxt = S_D_CS; end
      S_D_CS:  begin cs = 1'b0; if (phase_last) state_nxt = S_D_STB; end
      S_D_STB: begin
        cs = 1'b0;
        if (is_read) rd = 1'b0;
        else begin
          wr    = 1'b0;
          ADout = wf_mem[wf_rp];
        end
        if (phase_last) state_nxt = S_D_END;
      end
      S_D_END: if (phase_last) state_nxt = S_RECOV;
      S_RECOV: if (phase_last) state_nxt = burst_done ? S_IDLE : S_A_AL;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_reg   <= '1;
      addr_dirty <= 1'b0;
      count_reg  <= (AW+1)'(1);
      remaining  <= (AW+1)'(1);
      cur_addr   <= '1;
      is_read    <= 1'b0;
      err        <= 1'b0;
      ready      <= 8'h00;
    end else begin
      // A completed auto-increment burst leaves start+k behind unless the host
      // has already written a new address for the next command.
      if (port_addr_wr) begin
        addr_reg   <= dpico;
        addr_dirty <= 1'b1;
      end else if (AUTOINC && burst_done && !addr_dirty) begin
        addr_reg <= cur_addr + DW'(1);
      end
      if (port_cnt_wr) begin
        if (dpico == '0)               count_reg <= (AW+1)'(1);
        else if (dpico > DW'(DEPTH))   count_reg <= (AW+1)'(DEPTH);
        else                           count_reg <= dpico[AW:0];
      end
      if (start) begin
        if (!port_addr_wr) addr_dirty <= 1'b0;
        remaining <= count_reg;
        cur_addr  <= addr_reg;
        is_read   <= cmd_rd;
        err       <= 1'b0;
        ready     <= 8'h00;
      end else if (reject) begin
        err <= 1'b1;
      end
      if (xfer_done) begin
        remaining <= remaining - (AW+1)'(1);
        if (AUTOINC) cur_addr <= cur_addr + DW'(1);
      end
      if (burst_done) ready <= 8'hFF;
    end
  end

  always_ff @(posedge clock) begin
    if (wf_push) wf_mem[wf_wp] <= dpico;
    if (rf_push) rf_mem[rf_wp] <= ADin;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wf_wp  <= '0;
      wf_rp  <= '0;
      wf_cnt <= '0;
    end else begin
      if (wf_push) wf_wp <= wf_wp + AW'(1);
      if (wf_pop)  wf_rp <= wf_rp + AW'(1);
      case ({wf_push, wf_pop})
        2'b10:   wf_cnt <= wf_cnt + (AW+1)'(1);
        2'b01:   wf_cnt <= wf_cnt - (AW+1)'(1);
        default: wf_cnt <= wf_cnt;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rf_wp  <= '0;
      rf_rp  <= '0;
      rf_cnt <= '0;
    end else if (rf_clr) begin
      rf_wp  <= '0;
      rf_rp  <= '0;
      rf_cnt <= '0;
    end else begin
      if (rf_push) rf_wp <= rf_wp + AW'(1);
      if (rf_pop)  rf_rp <= rf_rp + AW'(1);
      case ({rf_push, rf_pop})
        2'b10:   rf_cnt <= rf_cnt + (AW+1)'(1);
        2'b01:   rf_cnt <= rf_cnt - (AW+1)'(1);
        default: rf_cnt <= rf_cnt;
      endcase
    end
  end

  assign status = {ready[7], 3'b000, err, wf_full, (rf_cnt != '0), busy};

  always_comb begin
    port_out = '0;
    case (id_port)
      8'h04:   if (rf_cnt != '0) port_out = rf_mem[rf_rp];
      8'h05:   port_out = DW'(status);
      default: port_out = '0;
    endcase
  end

endmodule

// File: tb/tb_rtc_bus_master.sv
// tb_rtc_bus_master: table-driven port checks plus directed bus sequences against a small RTC chip model.
// Honours RTCBUS_AUTOINC_EN for the expected burst addresses.
module tb_rtc_bus_master;

`ifdef RTCBUS_AUTOINC_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       writef, readf;
  logic [7:0] id_port, dpico, port_out, ADin, ADout, ready;
  logic       ad, cs, wr, rd, Pup, busy;
  logic [3:0] dbg_state;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  rtc_bus_master dut (
    .clock(clock), .reset(reset), .writef(writef), .readf(readf),
    .id_port(id_port), .dpico(dpico), .port_out(port_out),
    .ADin(ADin), .ADout(ADout), .ad(ad), .cs(cs), .wr(wr), .rd(rd),
    .Pup(Pup), .ready(ready), .busy(busy), .dbg_state(dbg_state)
  );

  // RTC chip model: latches the address on a wr-low with ad low, stores data on a
  // wr-low with ad high, and drives its register onto ADin while rd is low.
  logic [7:0] mem [256];
  logic [7:0] lat_addr = 8'h00;
  logic       prev_wr = 1'b1;
  logic [7:0] addr_q[$];
  logic [7:0] data_q[$];
  int wr_low_cycles = 0, rd_low_cycles = 0, pup_cycles = 0, proto_bad = 0;

  assign ADin = (rd == 1'b0) ? mem[lat_addr] : 8'h5A;

  always @(negedge clock) begin
    if (!reset) begin
      if (!wr) wr_low_cycles++;
      if (!rd) rd_low_cycles++;
      if (Pup) pup_cycles++;
      if (!wr && prev_wr) begin
        if (!ad) begin
          lat_addr = ADout;
          addr_q.push_back(ADout);
        end else begin
          mem[lat_addr] = ADout;
          data_q.push_back(ADout);
        end
      end
      if ((!wr || !rd) && cs) proto_bad++;
      if (Pup && (!wr || !rd)) proto_bad++;
    end
    prev_wr = wr;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    addr_q.delete();
    data_q.delete();
    wr_low_cycles = 0;
    rd_low_cycles = 0;
    pup_cycles    = 0;
  endtask

  task automatic port_write(input logic [7:0] id, input logic [7:0] d);
    @(negedge clock);
    writef = 1'b1; id_port = id; dpico = d;
    @(posedge clock);
    #1 writef = 1'b0; id_port = 8'h10;
  endtask

  task automatic port_read(input string name, input logic [7:0] id, input logic [7:0] exp);
    @(negedge clock);
    readf = 1'b1; id_port = id;
    #1 check(name, port_out, exp);
    @(posedge clock);
    #1 readf = 1'b0; id_port = 8'h10;
  endtask

  // Counts busy cycles after a command write; optionally re-issues a write
  // command at cycle poke_at while the transfer is running.
  task automatic wait_idle(input int poke_at, output int cycles);
    bit done;
    done   = 1'b0;
    cycles = 0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clock);
      if (i == 0) check("ready_running", ready, 8'h00);
      if (poke_at >= 0 && i == poke_at) begin
        writef = 1'b1; id_port = 8'h01; dpico = 8'h02;
      end
      if (poke_at >= 0 && i == poke_at + 1) begin
        writef = 1'b0; id_port = 8'h10;
      end
      if (busy) cycles++;
      else done = 1'b1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL busy_timeout: got busy=1 after %0d cycles expected idle", cycles);
    end
  endtask

  typedef struct {
    logic       wf;
    logic       rf;
    logic [7:0] id;
    logic [7:0] d;
    logic [7:0] exp;
    string      name;
  } vec_t;
  vec_t vecs[$];

  function automatic void add_vec(input logic wf, input logic rf, input logic [7:0] id,
                                  input logic [7:0] d, input logic [7:0] exp, input string name);
    vec_t v;
    v.wf = wf; v.rf = rf; v.id = id; v.d = d; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endfunction

  initial begin
    int cyc;
    bit found;
    logic [7:0] ea;
    logic [7:0] eq[$];

    writef = 1'b0; readf = 1'b0; id_port = 8'h10; dpico = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = ~8'(i);
    mem[8'h23] = 8'h45;

    // reset state
    repeat (3) @(negedge clock);
    check("rst_strobes", {ad, cs, wr, rd}, 4'hF);
    check("rst_adout", ADout, 8'hFF);
    check("rst_pup", Pup, 1'b0);
    check("rst_ready", ready, 8'h00);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;

    // port register behaviour: empty pops, rejected write, full write FIFO
    add_vec(0, 1, 8'h05, 8'h00, 8'h00, "st_reset");
    add_vec(0, 1, 8'h04, 8'h00, 8'h00, "pop_empty");
    add_vec(0, 1, 8'h09, 8'h00, 8'h00, "id_other");
    add_vec(1, 0, 8'h02, 8'hAA, 8'h00, "push_aa");
    add_vec(0, 1, 8'h05, 8'h00, 8'h00, "st_one_entry");
    add_vec(1, 0, 8'h03, 8'h02, 8'h00, "count_2");
    add_vec(1, 0, 8'h01, 8'h02, 8'h00, "cmd_reject");
    add_vec(0, 1, 8'h05, 8'h00, 8'h08, "st_reject");
    add_vec(1, 0, 8'h02, 8'hBB, 8'h00, "push_bb");
    add_vec(1, 0, 8'h02, 8'hCC, 8'h00, "push_cc");
    add_vec(1, 0, 8'h02, 8'hDD, 8'h00, "push_dd");
    add_vec(0, 1, 8'h05, 8'h00, 8'h0C, "st_wfull");
    add_vec(1, 0, 8'h02, 8'hEE, 8'h00, "push_drop");
    add_vec(0, 1, 8'h05, 8'h00, 8'h0C, "st_still_full");
    add_vec(1, 0, 8'h01, 8'h07, 8'h00, "cmd_bad");
    add_vec(0, 1, 8'h05, 8'h00, 8'h0C, "st_after_bad");
    foreach (vecs[i]) begin
      @(negedge clock);
      writef = vecs[i].wf; readf = vecs[i].rf; id_port = vecs[i].id; dpico = vecs[i].d;
      #1 check(vecs[i].name, port_out, vecs[i].exp);
      @(posedge clock);
      #1 writef = 1'b0; readf = 1'b0; id_port = 8'h10;
    end
    check("busy_after_table", busy, 1'b0);

    // full-FIFO burst write drains AA..DD; the dropped EE never appears
    clear_logs();
    port_write(8'h03, 8'h04);
    port_write(8'h00, 8'h50);
    port_write(8'h01, 8'h02);
    wait_idle(-1, cyc);
    check("wr4_cycles", cyc, 164);
    eq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    check("wr4_count", data_q.size(), 4);
    foreach (eq[i]) check($sformatf("wr4_data%0d", i), data_q[i], eq[i]);
    port_read("wr4_status", 8'h05, 8'h80);

    // single read
    clear_logs();
    port_write(8'h00, 8'h23);
    port_write(8'h03, 8'h01);
    port_write(8'h01, 8'h01);
    wait_idle(-1, cyc);
    check("rd1_cycles", cyc, 41);
    check("rd1_pup", pup_cycles, 9);
    check("rd1_rd_low", rd_low_cycles, 6);
    check("rd1_addr_n", addr_q.size(), 1);
    check("rd1_addr", addr_q[0], 8'h23);
    check("rd1_ready", ready, 8'hFF);
    port_read("rd1_status", 8'h05, 8'h82);
    port_read("rd1_data", 8'h04, 8'h45);
    port_read("rd1_status_empty", 8'h05, 8'h80);

    // burst write of three
    clear_logs();
    port_write(8'h02, 8'h11);
    port_write(8'h02, 8'h22);
    port_write(8'h02, 8'h33);
    port_write(8'h03, 8'h03);
    port_write(8'h00, 8'h20);
    port_write(8'h01, 8'h02);
    wait_idle(-1, cyc);
    check("wr3_cycles", cyc, 123);
    check("wr3_wr_low", wr_low_cycles, 36);
    check("wr3_pup", pup_cycles, 0);
    check("wr3_addr_n", addr_q.size(), 3);
    check("wr3_data_n", data_q.size(), 3);
    eq = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++) begin
      ea = AUTO ? 8'(8'h20 + i) : 8'h20;
      check($sformatf("wr3_addr%0d", i), addr_q[i], ea);
      check($sformatf("wr3_data%0d", i), data_q[i], eq[i]);
    end
    port_read("wr3_status", 8'h05, 8'h80);

    // next command reuses the address register left by the burst
    clear_logs();
    port_write(8'h03, 8'h01);
    port_write(8'h01, 8'h01);
    wait_idle(-1, cyc);
    check("post_addr", addr_q[0], AUTO ? 8'h23 : 8'h20);
    port_read("post_data", 8'h04, AUTO ? 8'h45 : 8'h33);

    // clamp to DEPTH and wrap the address
    clear_logs();
    port_write(8'h00, 8'hFF);
    port_write(8'h03, 8'h09);
    port_write(8'h01, 8'h01);
    wait_idle(-1, cyc);
    check("clamp_cycles", cyc, 164);
    check("clamp_addr_n", addr_q.size(), 4);
    port_read("clamp_status", 8'h05, 8'h82);
    for (int i = 0; i < 4; i++) begin
      ea = AUTO ? 8'(8'hFF + i) : 8'hFF;
      check($sformatf("clamp_addr%0d", i), addr_q[i], ea);
      port_read($sformatf("clamp_data%0d", i), 8'h04, ~ea);
    end
    port_read("clamp_drained", 8'h05, 8'h80);

    // write command while a read runs is ignored
    clear_logs();
    port_write(8'h00, 8'h30);
    port_write(8'h03, 8'h01);
    port_write(8'h01, 8'h01);
    wait_idle(10, cyc);
    check("poke_cycles", cyc, 41);
    check("poke_addr", addr_q[0], 8'h30);
    check("poke_no_write", data_q.size(), 0);
    port_read("poke_status", 8'h05, 8'h82);
    port_read("poke_data", 8'h04, 8'hCF);

    // asynchronous reset in the data strobe
    port_write(8'h00, 8'h40);
    port_write(8'h03, 8'h02);
    port_write(8'h01, 8'h01);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clock);
      if (!rd) found = 1'b1;
    end
    check("arst_rd_seen", found, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("arst_strobes", {ad, cs, wr, rd}, 4'hF);
    check("arst_adout", ADout, 8'hFF);
    check("arst_ready", ready, 8'h00);
    check("arst_busy", busy, 1'b0);
    check("arst_pup", Pup, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    port_read("arst_status", 8'h05, 8'h00);

    check("protocol", proto_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
